// File: rtl/unsorter_ctrl.sv
// -----------------------------------------------------------------------------
// unsorter_ctrl
//   Frame controller for the symbol unsorter. On a frame request it latches the
//   modulation and routes each received symbol to bank A or bank B of the
//   splitter that belongs to that modulation. Banks alternate every G symbols,
//   with G = 1/2/3/4 for QPSK/QAM16/QAM64/QAM256. Each frame starts on bank A.
//
//   Optional feature (macro UNSORTER_OVERRUN_ERR_EN):
//     defined   : a symbol arriving while no frame is open sets a sticky err.
//                 err clears on the edge that accepts the next start.
//     undefined : err is tied to 0 and the overrun logic is not built.
//
// Parameters
//   FRAME_LEN  symbols per frame (2..255)
//   CNT_W      width of the symbol counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   M          modulation select: 00 QPSK, 01 QAM16, 10 QAM64, 11 QAM256
//   start      frame request, sampled in IDLE and DONE
//   valid_in   one received symbol is present this cycle
//   selQPSK    QPSK splitter select:   0 hold, 1 bank A, 2 bank B
//   selQAM16   QAM16 splitter select:  same encoding
//   selQAM64   QAM64 splitter select:  same encoding
//   selQAM256  QAM256 splitter select: same encoding
//   busy       high while a frame is being split
//   done       one-cycle pulse, coincides with the last select pulse
//   err        sticky overrun flag
//
// States
//   state | meaning
//   IDLE  | waiting for start
//   SPLIT | frame open, routing accepted symbols
//   DONE  | last symbol routed; start here chains the next frame
// -----------------------------------------------------------------------------
module unsorter_ctrl #(
   parameter int FRAME_LEN = 64,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] M,
   input  logic       start,
   input  logic       valid_in,
   output logic [1:0] selQPSK,
   output logic [1:0] selQAM16,
   output logic [1:0] selQAM64,
   output logic [1:0] selQAM256,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPLIT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(FRAME_LEN - 1);

   state_t           r_state;
   logic [1:0]       r_m_q;
   logic [CNT_W-1:0] r_sym_cnt;
   logic [1:0]       r_grp_cnt;
   logic             r_bank;
   logic [1:0]       r_sel_qpsk;
   logic [1:0]       r_sel_qam16;
   logic [1:0]       r_sel_qam64;
   logic [1:0]       r_sel_qam256;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_nxt;
   logic [1:0]       w_m_nxt;
   logic [CNT_W-1:0] w_sym_nxt;
   logic [1:0]       w_grp_nxt;
   logic             w_bank_nxt;
   logic [1:0]       w_sel_nxt;
   logic             w_done_nxt;

   // The group counter is a down-counter. Its reload value is G-1, which is
   // numerically equal to the modulation code itself (QPSK=0 .. QAM256=3).
   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m_q;
      w_sym_nxt   = r_sym_cnt;
      w_grp_nxt   = r_grp_cnt;
      w_bank_nxt  = r_bank;
      w_sel_nxt   = 2'd0;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = SPLIT;
               w_m_nxt     = M;
               w_sym_nxt   = '0;
               w_grp_nxt   = M;
               w_bank_nxt  = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SPLIT: begin
            if (valid_in) begin
               w_sel_nxt = r_bank ? 2'd2 : 2'd1;
               if (r_grp_cnt == 2'd0) begin
                  w_grp_nxt  = r_m_q;
                  w_bank_nxt = ~r_bank;
               end else begin
                  w_grp_nxt = r_grp_cnt - 2'd1;
               end
               if (r_sym_cnt == LAST_SYM) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
                  w_sym_nxt   = '0;
               end else begin
                  w_sym_nxt = r_sym_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_m_q        <= 2'd0;
         r_sym_cnt    <= '0;
         r_grp_cnt    <= 2'd0;
         r_bank       <= 1'b0;
         r_sel_qpsk   <= 2'd0;
         r_sel_qam16  <= 2'd0;
         r_sel_qam64  <= 2'd0;
         r_sel_qam256 <= 2'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_m_q        <= w_m_nxt;
         r_sym_cnt    <= w_sym_nxt;
         r_grp_cnt    <= w_grp_nxt;
         r_bank       <= w_bank_nxt;
         // Only the splitter of the latched modulation ever sees a select.
         r_sel_qpsk   <= (r_m_q == 2'd0) ? w_sel_nxt : 2'd0;
         r_sel_qam16  <= (r_m_q == 2'd1) ? w_sel_nxt : 2'd0;
         r_sel_qam64  <= (r_m_q == 2'd2) ? w_sel_nxt : 2'd0;
         r_sel_qam256 <= (r_m_q == 2'd3) ? w_sel_nxt : 2'd0;
         r_busy       <= (w_state_nxt == SPLIT);
         r_done       <= w_done_nxt;
      end
   end

   assign selQPSK   = r_sel_qpsk;
   assign selQAM16  = r_sel_qam16;
   assign selQAM64  = r_sel_qam64;
   assign selQAM256 = r_sel_qam256;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef UNSORTER_OVERRUN_ERR_EN
   logic r_err;
   logic w_start_acc;
   logic w_overrun;

   assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_overrun   = valid_in && (r_state != SPLIT);

   // An accepted start wins over a same-cycle overrun: the new frame owns the
   // flag from that point on.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_start_acc) begin
         r_err <= 1'b0;
      end else if (w_overrun) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unsorter_ctrl.sv
module tb_unsorter_ctrl;

`ifdef UNSORTER_OVERRUN_ERR_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] M = 2'd0;
   logic       start = 1'b0;
   logic       valid_in = 1'b0;

   logic [1:0] a_q, a_16, a_64, a_256;
   logic       a_busy, a_done, a_err;
   logic [1:0] b_q, b_16, b_64, b_256;
   logic       b_busy, b_done, b_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   unsorter_ctrl #(.FRAME_LEN(8), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .M(M), .start(start), .valid_in(valid_in),
      .selQPSK(a_q), .selQAM16(a_16), .selQAM64(a_64), .selQAM256(a_256),
      .busy(a_busy), .done(a_done), .err(a_err)
   );

   unsorter_ctrl #(.FRAME_LEN(6), .CNT_W(8)) u_dut6 (
      .clk(clk), .rst(rst), .M(M), .start(start), .valid_in(valid_in),
      .selQPSK(b_q), .selQAM16(b_16), .selQAM64(b_64), .selQAM256(b_256),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_sels(input string tag, input logic [1:0] q, input logic [1:0] s16,
                           input logic [1:0] s64, input logic [1:0] s256,
                           input int m, input int sel);
      check_val({tag, ".qpsk"},   32'(q),    (m == 0) ? sel : 0);
      check_val({tag, ".qam16"},  32'(s16),  (m == 1) ? sel : 0);
      check_val({tag, ".qam64"},  32'(s64),  (m == 2) ? sel : 0);
      check_val({tag, ".qam256"}, 32'(s256), (m == 3) ? sel : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      start    = 1'b0;
      valid_in = 1'b0;
      rst      = 1'b0;
      #1;
      rst      = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      int pat [10];
      int exp3[10];
      pat  = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
      exp3 = '{1, 0, 1, 1, 0, 1, 2, 2, 2, 2};

      // reset state
      #2;
      chk_sels("rst", a_q, a_16, a_64, a_256, 0, 0);
      check_val("rst.busy", 32'(a_busy), 0);
      check_val("rst.done", 32'(a_done), 0);
      check_val("rst.err",  32'(a_err),  0);
      #1;
      rst = 1'b1;

      // QPSK, continuous symbols: A,B alternating every symbol
      M = 2'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t1.busy_start", 32'(a_busy), 1);
      chk_sels("t1.start", a_q, a_16, a_64, a_256, 0, 0);
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_sels($sformatf("t1.sym%0d", i), a_q, a_16, a_64, a_256, 0, (i % 2) ? 2 : 1);
         check_val($sformatf("t1.done%0d", i), 32'(a_done), (i == 7) ? 1 : 0);
         check_val($sformatf("t1.busy%0d", i), 32'(a_busy), (i < 7) ? 1 : 0);
      end
      valid_in = 1'b0;
      tick();
      chk_sels("t1.idle", a_q, a_16, a_64, a_256, 0, 0);
      check_val("t1.idle_done", 32'(a_done), 0);
      check_val("t1.idle_busy", 32'(a_busy), 0);

      // QAM16: pairs of A then pairs of B, busy for 8 cycles
      M = 2'd1; start = 1'b1;
      tick();
      start = 1'b0;
      busy_cnt = int'(a_busy);
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_sels($sformatf("t2.sym%0d", i), a_q, a_16, a_64, a_256, 1, ((i / 2) % 2) ? 2 : 1);
         check_val($sformatf("t2.done%0d", i), 32'(a_done), (i == 7) ? 1 : 0);
         busy_cnt += int'(a_busy);
      end
      check_val("t2.busy_cycles", busy_cnt, 8);
      valid_in = 1'b0;
      tick();

      // QAM256 with gaps; M moves mid-frame and must be ignored
      M = 2'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         valid_in = pat[i][0];
         if (i == 3) M = 2'd1;
         if (i == 6) M = 2'd2;
         tick();
         chk_sels($sformatf("t3.cyc%0d", i), a_q, a_16, a_64, a_256, 3, exp3[i]);
         check_val($sformatf("t3.done%0d", i), 32'(a_done), (i == 9) ? 1 : 0);
      end
      valid_in = 1'b0;
      tick();

      // FRAME_LEN=6, QAM64, start held high: back-to-back frames
      pulse_reset();
      M = 2'd2; start = 1'b1;
      tick();
      check_val("t4.busy_start", 32'(b_busy), 1);
      for (int f = 0; f < 2; f++) begin
         valid_in = 1'b1;
         for (int i = 0; i < 6; i++) begin
            tick();
            chk_sels($sformatf("t4.f%0d.sym%0d", f, i), b_q, b_16, b_64, b_256, 2, (i < 3) ? 1 : 2);
            check_val($sformatf("t4.f%0d.done%0d", f, i), 32'(b_done), (i == 5) ? 1 : 0);
         end
         valid_in = 1'b0;
         tick();
         check_val($sformatf("t4.f%0d.rebusy", f), 32'(b_busy), 1);
         check_val($sformatf("t4.f%0d.redone", f), 32'(b_done), 0);
         chk_sels($sformatf("t4.f%0d.gap", f), b_q, b_16, b_64, b_256, 2, 0);
      end
      start = 1'b0;
      tick();

      // reset in the middle of a QAM16 frame
      pulse_reset();
      M = 2'd1; start = 1'b1;
      tick();
      start = 1'b0;
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_sels($sformatf("t5.pre%0d", i), a_q, a_16, a_64, a_256, 1, (i < 2) ? 1 : 2);
      end
      #2;
      rst = 1'b0;
      #1;
      chk_sels("t5.async", a_q, a_16, a_64, a_256, 1, 0);
      check_val("t5.async_busy", 32'(a_busy), 0);
      check_val("t5.async_done", 32'(a_done), 0);
      check_val("t5.async_err",  32'(a_err),  0);
      tick();
      rst = 1'b1;
      tick();
      chk_sels("t5.nostart", a_q, a_16, a_64, a_256, 1, 0);
      check_val("t5.nostart_busy", 32'(a_busy), 0);
      check_val("t5.overrun_err", 32'(a_err), ERR_EN);
      valid_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t5.err_clear", 32'(a_err), 0);
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_sels($sformatf("t5.sym%0d", i), a_q, a_16, a_64, a_256, 1, ((i / 2) % 2) ? 2 : 1);
         check_val($sformatf("t5.done%0d", i), 32'(a_done), (i == 7) ? 1 : 0);
      end
      valid_in = 1'b0;
      tick();

      // overrun flag: set by a symbol in IDLE, sticky, cleared after start
      pulse_reset();
      check_val("t6.err_init", 32'(a_err), 0);
      valid_in = 1'b1;
      tick();
      check_val("t6.err_set", 32'(a_err), ERR_EN);
      valid_in = 1'b0;
      tick();
      check_val("t6.err_sticky", 32'(a_err), ERR_EN);
      M = 2'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t6.err_clr", 32'(a_err), 0);
      check_val("t6.busy", 32'(a_busy), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
